// File: rtl/signed_accum_pkg.sv
// Shared types and helpers for the signed packet accumulator.
//   state_t   : packet FSM state (IDLE = no beat of the current packet seen yet)
//   sat_limit : most-positive / most-negative two's complement value of a width
package signed_accum_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam int unsigned LIMIT_W = 64;

    // Returns 0 followed by w-1 ones (neg=0) or 1 followed by w-1 zeros (neg=1)
    // in the low w bits; callers truncate to their own width.
    function automatic logic [LIMIT_W-1:0] sat_limit(input int unsigned w, input logic neg);
        logic [LIMIT_W-1:0] max_pos;
        max_pos = (LIMIT_W'(1) << (w - 1)) - LIMIT_W'(1);
        return neg ? ~max_pos : max_pos;
    endfunction

endpackage

// File: rtl/signed_accum_sat_add.sv
// Combinational two's complement adder with optional saturation.
//   a, b     : signed operands (a is the running accumulator)
//   sat_en   : 1 = clamp on overflow, 0 = wrap
//   sum      : result, W bits
//   overflow : signed overflow of a + b (independent of sat_en)
module signed_add_sat
    import signed_accum_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sat_en,
    output logic [W-1:0] sum,
    output logic         overflow
);

    localparam logic [W-1:0] MAX_POS = W'(sat_limit(W, 1'b0));
    localparam logic [W-1:0] MIN_NEG = W'(sat_limit(W, 1'b1));

    logic [W-1:0] raw;

    // Overflow only when operands share a sign and the truncated result flips it.
    always_comb begin
        raw      = a + b;
        overflow = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
        sum      = raw;
        if (sat_en && overflow) begin
            sum = a[W-1] ? MIN_NEG : MAX_POS;
        end
    end

endmodule

// File: rtl/signed_accum_sat.sv
// Streaming signed packet accumulator with valid/ready in and out.
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   sat_en            : packet arithmetic mode, sampled on the first beat
//   up_valid/up_ready : input beat handshake; up_ready is combinational
//   up_data, up_last  : signed operand and end-of-packet marker
//   down_valid/ready  : result handshake
//   down_sum          : packet sum (wrapped or saturated)
//   down_overflow     : some beat of the packet overflowed
//   down_count        : beats in the packet, saturating at 2**CNT_W-1
module signed_accum_sat
    import signed_accum_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sat_en,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [W-1:0]     up_data,
    input  logic             up_last,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [W-1:0]     down_sum,
    output logic             down_overflow,
    output logic [CNT_W-1:0] down_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    logic [W-1:0]       acc;
    logic               sticky;
    logic [CNT_W-1:0]   count;
    logic               mode;

    logic               accept;
    logic               first;
    logic               add_sat;
    logic               add_ovf;
    logic [W-1:0]       add_sum;
    logic [CNT_W-1:0]   count_next;
    logic               sticky_next;

    // The output register can take a new result whenever it is empty or draining.
    assign up_ready = ~down_valid | down_ready;
    assign accept   = up_valid & up_ready;
    assign first    = (state == IDLE);

    // On the first beat the live sat_en applies; afterwards the latched mode.
    // acc, sticky and count are all zero in IDLE, so no first-beat muxing is
    // needed for them.
    assign add_sat     = first ? sat_en : mode;
    assign count_next  = (count == CNT_MAX) ? count : count + CNT_W'(1);
    assign sticky_next = sticky | add_ovf;

    signed_add_sat #(
        .W (W)
    ) u_add (
        .a        (acc),
        .b        (up_data),
        .sat_en   (add_sat),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    // Packet FSM, accumulator and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= '0;
            sticky        <= 1'b0;
            count         <= '0;
            mode          <= 1'b0;
            down_valid    <= 1'b0;
            down_sum      <= '0;
            down_overflow <= 1'b0;
            down_count    <= '0;
        end else begin
            if (down_valid && down_ready) begin
                down_valid <= 1'b0;
            end
            if (accept) begin
                if (up_last) begin
                    // Takes priority over the drain above: back-to-back results.
                    down_valid    <= 1'b1;
                    down_sum      <= add_sum;
                    down_overflow <= sticky_next;
                    down_count    <= count_next;
                    acc           <= '0;
                    sticky        <= 1'b0;
                    count         <= '0;
                    state         <= IDLE;
                end else begin
                    acc    <= add_sum;
                    sticky <= sticky_next;
                    count  <= count_next;
                    state  <= ACCUM;
                    if (first) begin
                        mode <= sat_en;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_signed_accum_sat.sv
// Bench for signed_accum_sat: a W=4 instance and a W=8/CNT_W=2 instance, each
// tracked by an integer-arithmetic packet model and checked every cycle, plus
// hand-computed expectations for the directed packets.
module tb_signed_accum_sat;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance 1: W=4, CNT_W=8
    logic       v1 = 0, l1 = 0, s1 = 0, dr1 = 1, r1, dv1, do1;
    logic [3:0] d1 = '0, ds1;
    logic [7:0] dc1;
    // Instance 2: W=8, CNT_W=2
    logic       v2 = 0, l2 = 0, s2 = 0, dr2 = 1, r2, dv2, do2;
    logic [7:0] d2 = '0, ds2;
    logic [1:0] dc2;

    signed_accum_sat #(.W(4), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .sat_en(s1), .up_valid(v1), .up_ready(r1),
        .up_data(d1), .up_last(l1), .down_valid(dv1), .down_ready(dr1),
        .down_sum(ds1), .down_overflow(do1), .down_count(dc1)
    );

    signed_accum_sat #(.W(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .sat_en(s2), .up_valid(v2), .up_ready(r2),
        .up_data(d2), .up_last(l2), .down_valid(dv2), .down_ready(dr2),
        .down_sum(ds2), .down_overflow(do2), .down_count(dc2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Packet model: plain integer sums, range test for overflow.
    typedef struct {
        int busy;   // some beat of the current packet taken
        int acc;
        int sticky;
        int cnt;
        int mode;
        int ov;     // result pending
        int osum;
        int oovf;
        int ocnt;
    } mdl_t;

    function automatic mdl_t mdl_zero();
        mdl_t m;
        m.busy = 0; m.acc = 0; m.sticky = 0; m.cnt = 0; m.mode = 0;
        m.ov = 0; m.osum = 0; m.oovf = 0; m.ocnt = 0;
        return m;
    endfunction

    function automatic mdl_t step(input mdl_t m, input int w, input int cw,
                                  input int valid, input int last, input int data,
                                  input int sat, input int dready);
        mdl_t n;
        int   s, hi, lo, o, c, md;
        n  = m;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (m.ov != 0 && dready != 0) n.ov = 0;
        if (valid != 0 && (m.ov == 0 || dready != 0)) begin
            md = (m.busy != 0) ? m.mode : sat;
            s  = ((m.busy != 0) ? m.acc : 0) + data;
            o  = (s > hi || s < lo) ? 1 : 0;
            if (o != 0) begin
                if (md != 0) s = (s > hi) ? hi : lo;
                else         s = (s > hi) ? s - (1 << w) : s + (1 << w);
            end
            c = ((m.busy != 0) ? m.cnt : 0) + 1;
            if (c > (1 << cw) - 1) c = (1 << cw) - 1;
            if (last != 0) begin
                n.ov = 1; n.osum = s; n.ocnt = c;
                n.oovf = ((m.busy != 0 && m.sticky != 0) || o != 0) ? 1 : 0;
                n.busy = 0; n.acc = 0; n.sticky = 0; n.cnt = 0;
            end else begin
                n.busy = 1; n.acc = s; n.cnt = c; n.mode = md;
                n.sticky = ((m.busy != 0 && m.sticky != 0) || o != 0) ? 1 : 0;
            end
        end
        return n;
    endfunction

    mdl_t m1, m2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1 <= mdl_zero();
            m2 <= mdl_zero();
        end else begin
            m1 <= step(m1, 4, 8, int'(v1), int'(l1), int'($signed(d1)), int'(s1), int'(dr1));
            m2 <= step(m2, 8, 2, int'(v2), int'(l2), int'($signed(d2)), int'(s2), int'(dr2));
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("dut1.down_valid", int'(dv1), m1.ov);
        check("dut1.up_ready", int'(r1), (m1.ov == 0 || dr1) ? 1 : 0);
        if (m1.ov != 0) begin
            check("dut1.down_sum", int'($signed(ds1)), m1.osum);
            check("dut1.down_overflow", int'(do1), m1.oovf);
            check("dut1.down_count", int'(dc1), m1.ocnt);
        end
        check("dut2.down_valid", int'(dv2), m2.ov);
        check("dut2.up_ready", int'(r2), (m2.ov == 0 || dr2) ? 1 : 0);
        if (m2.ov != 0) begin
            check("dut2.down_sum", int'($signed(ds2)), m2.osum);
            check("dut2.down_overflow", int'(do2), m2.oovf);
            check("dut2.down_count", int'(dc2), m2.ocnt);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic beat1(input int data, input logic last, input logic sat);
        v1 = 1'b1; d1 = 4'(data); l1 = last; s1 = sat;
    endtask

    // Hand-computed result check on instance 1 at the next falling edge.
    task automatic lit1(input string tag, input int v, input int s, input int o, input int c);
        @(negedge clk);
        #1;
        check({tag, " valid"}, int'(dv1), v);
        if (v != 0) begin
            check({tag, " sum"}, int'($signed(ds1)), s);
            check({tag, " ovf"}, int'(do1), o);
            check({tag, " count"}, int'(dc1), c);
        end
    endtask

    initial begin
        cyc();
        cyc();
        check("reset dut1 outputs", int'({dv1, ds1, do1, dc1}), 0);
        check("reset dut2 outputs", int'({dv2, ds2, do2, dc2}), 0);
        rst = 1'b0;

        // Wrap: 3 + 5 wraps to -8, -8 + -2 wraps to 6.
        cyc(); beat1(3, 0, 0);
        cyc(); beat1(5, 0, 0);
        cyc(); beat1(-2, 1, 0);
        cyc(); v1 = 0;
        lit1("wrap pkt", 1, 6, 1, 3);
        cyc();
        lit1("wrap pkt drained", 0, 0, 0, 0);

        // Saturate: 3 + 5 clamps to 7, 7 - 2 = 5; sat_en dropped after beat 1 is ignored.
        cyc(); beat1(3, 0, 1);
        cyc(); beat1(5, 0, 0);
        cyc(); beat1(-2, 1, 0);
        cyc(); v1 = 0;
        lit1("sat pkt", 1, 5, 1, 3);

        // Back-to-back: -4 + -7 clamps to -8, then single-beat 7 reloads same cycle.
        cyc(); beat1(-4, 0, 1);
        cyc(); beat1(-7, 1, 0);
        cyc(); beat1(7, 1, 1);
        lit1("b2b first", 1, -8, 1, 2);
        cyc(); v1 = 0;
        lit1("b2b second", 1, 7, 0, 1);

        // Backpressure: result 1 held, next beat stalled until down_ready.
        cyc(); beat1(1, 1, 0); dr1 = 0;
        cyc(); beat1(2, 1, 0);
        lit1("bp held a", 1, 1, 0, 1);
        check("bp up_ready low", int'(r1), 0);
        cyc();
        lit1("bp held b", 1, 1, 0, 1);
        cyc(); dr1 = 1;
        #1;
        check("bp up_ready follows down_ready", int'(r1), 1);
        cyc(); v1 = 0;
        lit1("bp next result", 1, 2, 0, 1);
        cyc();
        lit1("bp drained", 0, 0, 0, 0);

        // Reset mid-packet discards beats 2 and 3.
        cyc(); beat1(2, 0, 0);
        cyc(); beat1(3, 0, 0);
        cyc(); v1 = 0;
        rst = 1'b1;
        #1;
        check("mid reset outputs", int'({dv1, ds1, do1, dc1}), 0);
        cyc(); rst = 1'b0;
        cyc(); beat1(1, 1, 0);
        cyc(); v1 = 0;
        lit1("post reset pkt", 1, 1, 0, 1);

        // CNT_W=2: five beats of 1 -> sum 5, count saturates at 3.
        for (int i = 0; i < 5; i++) begin
            cyc(); v2 = 1; d2 = 8'd1; l2 = (i == 4); s2 = 0;
        end
        cyc(); v2 = 0;
        @(negedge clk);
        #1;
        check("cnt sat valid", int'(dv2), 1);
        check("cnt sat sum", int'($signed(ds2)), 5);
        check("cnt sat ovf", int'(do2), 0);
        check("cnt sat count", int'(dc2), 3);

        repeat (3) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/signed_accum_sat.md
Name: signed_accum_sat

Overview:
- Streaming signed (two's complement) packet accumulator.
- Sums every beat of an input packet and reports the total, a sticky overflow flag and the beat count.
- Packet sum is produced one cycle after the beat flagged last is accepted.
- Width is parametrised; each packet selects wrap-around or saturating arithmetic.
- Sits behind sample sources in the arithmetic/pipelining section; feeds downstream consumers over a valid/ready link.

Parameters:
W, 8, operand and sum width in bits (W >= 2)
CNT_W, 8, beat counter width; count saturates at 2**CNT_W-1

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
sat_en  input  1  1 = saturating mode, 0 = wrap mode; sampled on the first beat of each packet
up_valid  input  1  input beat valid
up_ready  output  1  block can accept a beat
up_data  input  W  signed operand
up_last  input  1  beat is the last of its packet
down_valid  output  1  result valid
down_ready  input  1  consumer accepts the result
down_sum  output  W  signed packet sum
down_overflow  output  1  at least one beat of the packet overflowed
down_count  output  CNT_W  number of beats in the packet, saturating

Behaviour:
- Reset values:
  - down_valid=0, down_sum=0, down_overflow=0, down_count=0.
  - Internal accumulator=0, sticky flag=0, beat count=0, mode=wrap.
  - FSM state=IDLE.
- Reset mid-packet discards the partial packet; an un-drained result is lost.
- Handshake:
  - Beat accepted when up_valid & up_ready.
  - Result consumed when down_valid & down_ready.
  - up_ready = ~down_valid | down_ready. This is combinational from down_ready and applies to every beat, not only the last.
  - down_* outputs stay stable while down_valid & ~down_ready.
- FSM:
  - IDLE: no beats of the current packet yet accepted.
  - ACCUM: at least one beat accepted, last not yet seen.
  - IDLE + accepted beat, up_last=0 -> ACCUM. Latches sat_en as the packet mode; the accumulator loads up_data.
  - IDLE + accepted beat, up_last=1 -> IDLE. Single-beat packet: result = up_data, overflow=0, count=1.
  - ACCUM + accepted beat, up_last=0 -> ACCUM. Accumulate.
  - ACCUM + accepted beat, up_last=1 -> IDLE. Accumulate the final beat, load the output register, clear the accumulator, sticky flag and count.
- Arithmetic, per accepted beat:
  - raw = acc + up_data, truncated to W bits.
  - ovf = (acc[W-1] == up_data[W-1]) & (raw[W-1] != acc[W-1]).
  - Wrap mode: next = raw.
  - Saturating mode with ovf: next = max positive (0 followed by W-1 ones) when acc is non-negative, otherwise min negative (1 followed by W-1 zeros).
  - Saturating mode without ovf: next = raw.
  - The sticky flag ORs in ovf. down_overflow = sticky | ovf of the last beat.
- Count: increments per accepted beat and holds at 2**CNT_W-1.
- Latency: down_valid rises on the edge that accepts the last beat and is visible the cycle after.
- Throughput: one beat per cycle.
  - Back-to-back packets are allowed.
  - A last beat may be accepted in the same cycle the previous result is consumed; the output register reloads and down_valid stays 1.
- sat_en is ignored on non-first beats.

Decomposition:
- Package signed_accum_pkg: fsm state enum (IDLE, ACCUM) and a function returning the max and min signed constants for a given width.
- Sub-module signed_add_sat (combinational, parameter W):
  - Inputs: a, b, sat_en.
  - Outputs: sum, overflow.
  - Implements the arithmetic rules above and is instantiated once.
- Registers, FSM and handshake logic live in signed_accum_sat.

Test Plan:
- W=4, wrap mode, packet 3,5,-2(last), down_ready=1 -> down_sum=6, down_overflow=1, down_count=3, down_valid for 1 cycle.
- W=4, saturating mode, packet 3,5,-2(last) -> intermediate sum clamps to 7, down_sum=5, down_overflow=1, down_count=3.
- W=4, saturating mode, packets -4,-7(last) then 7(last) back-to-back -> first result -8 with overflow=1, count=2; next cycle 7 with overflow=0, count=1.
- Backpressure: down_ready=0 while result 1 pending -> up_ready=0, beats held, outputs stable; down_ready=1 -> result consumed and next beat accepted in the same cycle.
- Reset asserted mid-packet after beats 2,3 -> outputs 0 immediately; after release, packet 1(last) -> down_sum=1, count=1, overflow=0.
- CNT_W=2, wrap mode, packet of 5 beats of 1 -> down_count=3 (saturated), down_sum=5 with W=8, overflow=0.
